// File: rtl/arb_requester.sv
// Per-channel pending-request counters facing an external arbiter, with grant error checking.
// Define ARB_REQ_STARVE_CHECK_EN to enable the per-channel starvation monitor on starve_o.
module arb_requester #(
    parameter int NUM          = 4,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NUM-1:0] push_i,
    output logic [NUM-1:0] full_o,
    output logic [NUM-1:0] req_o,
    input  logic [NUM-1:0] gnt_i,
    output logic [NUM-1:0] served_o,
    output logic           ovf_o,
    output logic           err_multi_gnt_o,
    output logic           err_spur_gnt_o,
    output logic [NUM-1:0] starve_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [NUM-1:0] VEC_ONE = NUM'(1);

    logic [CW-1:0]  count_q [NUM];
    logic [CW-1:0]  count_d [NUM];
    logic           gnt_multi;
    logic           gnt_onehot;
    logic [NUM-1:0] acc;
    logic [NUM-1:0] inc;
    logic [NUM-1:0] drop;
    logic [NUM-1:0] spur;

    // Outputs decode from registered counts only; push/gnt never reach them combinationally.
    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            req_o[k]  = (count_q[k] != '0);
            full_o[k] = (count_q[k] == CNT_FULL);
        end
    end

    always_comb begin
        gnt_multi  = ((gnt_i & (gnt_i - VEC_ONE)) != '0);
        gnt_onehot = (gnt_i != '0) && !gnt_multi;
        acc        = gnt_onehot ? (gnt_i & req_o) : '0;
        spur       = gnt_i & ~req_o;
        // A push into a full channel survives only if that channel is served on the same edge.
        inc        = push_i & (~full_o | acc);
        drop       = push_i & full_o & ~acc;
        for (int k = 0; k < NUM; k++) begin
            count_d[k] = count_q[k];
            case ({inc[k], acc[k]})
                2'b10:   count_d[k] = count_q[k] + CNT_ONE;
                2'b01:   count_d[k] = count_q[k] - CNT_ONE;
                default: count_d[k] = count_q[k];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM; k++) count_q[k] <= '0;
            served_o        <= '0;
            ovf_o           <= 1'b0;
            err_multi_gnt_o <= 1'b0;
            err_spur_gnt_o  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM; k++) count_q[k] <= count_d[k];
            served_o <= acc;
            if (drop != '0) ovf_o           <= 1'b1;
            if (gnt_multi)  err_multi_gnt_o <= 1'b1;
            if (spur != '0) err_spur_gnt_o  <= 1'b1;
        end
    end

`ifdef ARB_REQ_STARVE_CHECK_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);

    logic [WW-1:0] wait_q [NUM];

    // Wait counters run only while a channel is pending and unserved; saturate at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM; k++) wait_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM; k++) begin
                if (acc[k] || !req_o[k])
                    wait_q[k] <= '0;
                else if (wait_q[k] != WAIT_MAX)
                    wait_q[k] <= wait_q[k] + WAIT_ONE;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM; k++) starve_o[k] = (wait_q[k] == WAIT_MAX);
    end
`else
    assign starve_o = '0;
`endif

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter NUM, default 4: number of requester channels; legal range 2..16.
REQ-002 Parameter DEPTH, default 4: maximum pending requests per channel; legal range 1..15.
REQ-003 Parameter STARVE_LIMIT, default 8: wait cycles before starvation flag; legal range 1..255.
REQ-004 clk  input  1: single clock, all state on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 push_i  input  NUM: per-channel one-cycle pulse adding one pending request.
REQ-007 full_o  output  NUM: channel pending count equals DEPTH.
REQ-008 req_o  output  NUM: request vector driven to the arbiter; bit k high iff channel k pending count nonzero.
REQ-009 gnt_i  input  NUM: grant vector returned by the arbiter, sampled each rising edge.
REQ-010 served_o  output  NUM: one-cycle pulse, cycle after an accepted grant.
REQ-011 ovf_o  output  1: sticky, push to a full channel occurred.
REQ-012 err_multi_gnt_o  output  1: sticky, gnt_i had more than one bit set.
REQ-013 err_spur_gnt_o  output  1: sticky, gnt_i bit set on a channel with req_o low.
REQ-014 starve_o  output  NUM: channel k waiting at least STARVE_LIMIT cycles (only with macro, REQ-031).

Function
REQ-015 Each channel holds a registered pending count, 0..DEPTH; req_o and full_o decode from registered counts only, no combinational path from push_i or gnt_i.
REQ-016 Accepted grant: gnt_i onehot with bit k set and req_o[k] high; count[k] decrements by 1 at that edge, served_o[k] high for exactly the following cycle.
REQ-017 Push on a non-full channel increments count[k] at that edge; req_o[k] rises the cycle after first push (latency 1).
REQ-018 Push and accepted grant on the same channel, same edge: count unchanged, served_o[k] still pulses.
REQ-019 Push when count equals DEPTH and no accepted grant that edge: push dropped, ovf_o set; with simultaneous accepted grant the push is kept (count stays DEPTH).
REQ-020 gnt_i with two or more bits set: no count changes from grants that edge, no served_o, err_multi_gnt_o set; pushes still processed.
REQ-021 gnt_i bit k set while req_o[k] low: ignored, err_spur_gnt_o set; an onehot grant is never both accepted and spurious.
REQ-022 gnt_i all zero: no grant effect, no error.
REQ-023 Sticky error flags clear only on reset.
REQ-024 Count never wraps: no decrement below 0, no increment above DEPTH.

Reset
REQ-025 rst_n low asynchronously clears all counts, wait counters, and sticky flags.
REQ-026 During reset: req_o, full_o, served_o, starve_o all zero; ovf_o, err_multi_gnt_o, err_spur_gnt_o zero.
REQ-027 Reset mid-operation discards all pending requests; no served_o pulse for grants sampled in the first edge after release if req_o was low.
REQ-028 Push and gnt_i are ignored while rst_n is low; first effective edge is the first rising edge with rst_n high.

Configuration
REQ-029 Macro ARB_REQ_STARVE_CHECK_EN controls starvation monitoring.
REQ-030 Defined: per-channel wait counter increments each cycle req_o[k] high without accepted grant, saturates at STARVE_LIMIT, clears on accepted grant or when count reaches 0.
REQ-031 Defined: starve_o[k] high while wait counter k equals STARVE_LIMIT; registered.
REQ-032 Undefined: no wait counters synthesized, starve_o tied to zero, all other behaviour identical.

Verification (NUM=4, DEPTH=4, STARVE_LIMIT=8)
REQ-033 Push ch0 once, gnt_i=0001 next cycle -> req_o=0001 then 0000, served_o=0001 for one cycle, no errors.
REQ-034 Push ch2 five times with gnt_i=0 -> full_o[2] after fourth push, ovf_o=1 after fifth, count stays 4.
REQ-035 Ch1 count 2, same-edge push ch1 and gnt_i=0010 -> count stays 2, served_o=0010, req_o[1] stays high.
REQ-036 Ch0 and ch3 pending, gnt_i=1001 -> err_multi_gnt_o=1, counts unchanged, served_o=0000; then gnt_i=0100 with ch2 idle -> err_spur_gnt_o=1.
REQ-037 Macro defined, ch3 pending, gnt_i=0 for 8 cycles -> starve_o=1000; gnt_i=1000 -> starve_o clears next cycle; macro undefined -> starve_o always 0000.
REQ-038 Three channels pending, rst_n low mid-cycle -> req_o=0000 and all flags 0 immediately, gnt_i=0001 at first edge after release -> no served_o, err_spur_gnt_o=1.
